dff_bank_ctrl: RTL
==================

# dff_bank_ctrl

Round-robin controller that shares one W-bit bank of D flip-flops (active-low async set/clear per cell) between NREQ requesters. It arbitrates requests, then sequences write, preset or clear operations onto the bank's D, S_n, R_n and capture-strobe lines, and acknowledges each requester on completion. It sits between requester logic and the flip-flop bank, and is the only driver of the bank's control pins.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 8, bank width in bits
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request level
- op  in  2*NREQ  per-requester opcode, slice [2i+1:2i]: 00 write, 01 set, 10 clear, 11 hold
- wdata  in  W*NREQ  per-requester write data, slice [W*i+W-1:W*i]
- q  in  W  bank Q outputs (readback)
- d  out  W  bank D inputs
- s_n  out  1  bank preset, active-low, all bits
- r_n  out  1  bank clear, active-low, all bits
- cap  out  1  bank capture strobe (clock enable), one-cycle pulse
- gnt  out  NREQ  one-hot grant, held for the whole operation
- ack  out  NREQ  one-hot, one-cycle completion pulse
- busy  out  1  high in every state except IDLE
- err  out  1  verify-mismatch pulse, coincident with ack (VERIFY_EN only)

## Operation
- All outputs registered; reset values: d=0, s_n=1, r_n=1, cap=0, gnt=0, ack=0, busy=0, err=0; round-robin pointer ptr=0; state IDLE.
- States: IDLE -> DRIVE -> STROBE -> [VERIFY] -> ACK -> IDLE.
- IDLE: if any req bit set, pick winner = first set bit searching from ptr upward, wrapping at NREQ-1 -> 0. Latch winner's op and wdata. Go to DRIVE. No req: stay.
- DRIVE: gnt[winner]=1, busy=1. write: d=latched data. set: s_n=0. clear: r_n=0. hold: no pin activity.
- STROBE: write: cap=1, d held. set/clear: s_n, r_n return to 1 (pulse exactly one cycle). hold: idle cycle.
- VERIFY (VERIFY_EN only): compare q with expected value (write: data; set: all ones; clear: all zeros; hold: no compare).
- ACK: ack[winner]=1 for one cycle, gnt drops the same cycle. err as below. ptr = winner+1 mod NREQ. Return to IDLE.
- s_n and r_n are never low in the same cycle; cap is never high while s_n or r_n is low.
- Request latched at grant: req dropped or op/wdata changed after the IDLE sample has no effect; the op completes and is acked.
- A requester still asserting req after its ack is treated as a new request, but only wins when arbitration reaches it again.
- rst asserted in any state: next edge forces reset values, aborts the op with no ack, ptr=0.

## Timing
- Cycle 0 (IDLE samples req) -> gnt at cycle 1 -> cap (write) or S_n/R_n pulse at cycle 1/2 as above -> ack at cycle 3 (cycle 4 with VERIFY_EN).
- Throughput: one op per 4 cycles (5 with VERIFY_EN); the mandatory IDLE cycle lies between operations.
- busy rises with gnt and falls the cycle after ack.

## Configuration
- DFF_BANK_VERIFY_EN defined: VERIFY state present. q is sampled in VERIFY and err is pulsed with ack on a mismatch.
- Not defined: VERIFY omitted, STROBE goes directly to ACK, err tied to 0.

## Test plan
- Reset: hold rst=1 for 2 cycles with req=4'b1111 -> all outputs at reset values, no gnt.
- Single write: req[2]=1, op=00, wdata[2]=8'hA5 -> gnt=4'b0100 at cycle 1, d=8'hA5, cap pulse at cycle 2, ack[2] at cycle 3 (4 with verify).
- Round robin: req=4'b1111 held, all writes -> grant order 0,1,2,3,0; each ack 4 cycles apart (5 with verify).
- Set/clear: req0 op=01, then req1 op=10 -> exactly one-cycle s_n=0, later one-cycle r_n=0, never overlapping, cap stays 0.
- Reset mid-op: assert rst in STROBE of a write -> no ack, outputs reset next edge, next grant searches from requester 0.
- Verify (macro on): bench model forces q=8'h00 after a write of 8'h3C -> err=1 coincident with ack; correct q -> err=0.

Source files
------------

// File: rtl/dff_bank_ctrl.sv
// Round-robin controller that time-shares one W-bit flip-flop bank between NREQ requesters.
// Define DFF_BANK_VERIFY_EN to add a readback VERIFY state that pulses err with ack on a mismatch.
module dff_bank_ctrl #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [2*NREQ-1:0]   op,
    input  logic [W*NREQ-1:0]   wdata,
    input  logic [W-1:0]        q,
    output logic [W-1:0]        d,
    output logic                s_n,
    output logic                r_n,
    output logic                cap,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     ack,
    output logic                busy,
    output logic                err
);

    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW1 = PW + 1;

    typedef enum logic [2:0] {IDLE, DRIVE, STROBE, VERIFY, ACK} state_t;
    typedef enum logic [1:0] {OP_WRITE = 2'b00, OP_SET = 2'b01, OP_CLEAR = 2'b10, OP_HOLD = 2'b11} op_t;

    state_t          state;
    op_t             cur_op;
    op_t             pick_op;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   winner;
    logic [PW-1:0]   pick;
    logic [PW:0]     idx;
    logic [W-1:0]    pick_data;
    logic [NREQ-1:0] pick_onehot;
    logic [NREQ-1:0] winner_onehot;

    // Search downward from the farthest offset so the requester nearest ptr is the last one assigned.
    always_comb begin
        idx           = '0;
        pick          = ptr;
        pick_op       = OP_HOLD;
        pick_data     = '0;
        pick_onehot   = '0;
        winner_onehot = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + PW1'(i);
            if (idx >= PW1'(NREQ)) idx = idx - PW1'(NREQ);
            if (req[idx[PW-1:0]]) pick = idx[PW-1:0];
        end
        for (int i = 0; i < NREQ; i++) begin
            if (PW'(i) == pick) begin
                pick_op        = op_t'(op[2*i +: 2]);
                pick_data      = wdata[W*i +: W];
                pick_onehot[i] = 1'b1;
            end
            if (PW'(i) == winner) winner_onehot[i] = 1'b1;
        end
    end

    // Pin outputs are assigned for the state being entered, so every output is a plain register.
    // d keeps the last written value between operations; only a write or reset changes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cur_op <= OP_HOLD;
            ptr    <= '0;
            winner <= '0;
            d      <= '0;
            s_n    <= 1'b1;
            r_n    <= 1'b1;
            cap    <= 1'b0;
            gnt    <= '0;
            ack    <= '0;
            busy   <= 1'b0;
            err    <= 1'b0;
        end else begin
            s_n <= 1'b1;
            r_n <= 1'b1;
            cap <= 1'b0;
            ack <= '0;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state  <= DRIVE;
                        winner <= pick;
                        cur_op <= pick_op;
                        gnt    <= pick_onehot;
                        busy   <= 1'b1;
                        case (pick_op)
                            OP_WRITE: d   <= pick_data;
                            OP_SET:   s_n <= 1'b0;
                            OP_CLEAR: r_n <= 1'b0;
                            default:  ;
                        endcase
                    end
                end
                DRIVE: begin
                    state <= STROBE;
                    if (cur_op == OP_WRITE) cap <= 1'b1;
                end
                STROBE: begin
`ifdef DFF_BANK_VERIFY_EN
                    state <= VERIFY;
`else
                    state <= ACK;
                    gnt   <= '0;
                    ack   <= winner_onehot;
`endif
                end
`ifdef DFF_BANK_VERIFY_EN
                // d still holds the written data here, so it doubles as the expected readback.
                VERIFY: begin
                    state <= ACK;
                    gnt   <= '0;
                    ack   <= winner_onehot;
                    case (cur_op)
                        OP_WRITE: err <= (q != d);
                        OP_SET:   err <= (q != {W{1'b1}});
                        OP_CLEAR: err <= (q != {W{1'b0}});
                        default:  err <= 1'b0;
                    endcase
                end
`endif
                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ptr   <= (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef DFF_BANK_VERIFY_EN
    logic unused_q;
    assign unused_q = ^q;
`endif

endmodule
